// File: rtl/voice_pkg.sv
// voice_pkg -- shared definitions for the voice capture path.
//
// Holds the I2S receiver FSM state encoding (one-hot), the CHANNEL_SEL
// codes and the default sample width.  The sample width matches the
// sdramfifo word, so FIFO users import this package as well.
//
// No ports (package).
package voice_pkg;

    // Default sample width, equal to the downstream sdramfifo word width.
    localparam int DEFAULT_DATA_WIDTH = 16;

    // CHANNEL_SEL codes.
    localparam int CH_LEFT  = 0;   // capture lrclk-low words only
    localparam int CH_RIGHT = 1;   // capture lrclk-high words only
    localparam int CH_BOTH  = 2;   // capture both, interleaved L,R

    // One-hot receiver states.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_DELAY = 4'b0010,
        ST_SHIFT = 4'b0100,
        ST_WAIT  = 4'b1000
    } state_e;

endpackage

// File: rtl/sync_edge.sv
// sync_edge -- two-flop synchroniser with rising-edge detect.
//
// The edge input (codec bit clock) is synchronised and its 0->1
// transition is reported as a one-cycle o_rise pulse, three i_clk edges
// after the input rises.  The companion data inputs (word select and
// serial data) only pass through the two-flop synchroniser so that they
// can be sampled on o_rise.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset (clears all flops)
//   i_edge       asynchronous input whose rising edge is detected
//   i_data       asynchronous inputs, synchronised only
//   o_rise       one-cycle pulse per rising edge of i_edge
//   o_data_sync  synchronised i_data
module sync_edge
    import voice_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_edge,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_rise,
    output logic [WIDTH-1:0] o_data_sync
);

    logic             edge_meta_q;
    logic             edge_sync_q;
    logic             edge_prev_q;
    logic             rise_q;
    logic [WIDTH-1:0] data_meta_q;
    logic [WIDTH-1:0] data_sync_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            edge_meta_q <= 1'b0;
            edge_sync_q <= 1'b0;
            edge_prev_q <= 1'b0;
            rise_q      <= 1'b0;
            data_meta_q <= '0;
            data_sync_q <= '0;
        end else begin
            edge_meta_q <= i_edge;
            edge_sync_q <= edge_meta_q;
            edge_prev_q <= edge_sync_q;
            // Registered detect: the pulse lands on the third edge after
            // the input rises, while the data sync stays stable around it.
            rise_q      <= edge_sync_q & ~edge_prev_q;
            data_meta_q <= i_data;
            data_sync_q <= data_meta_q;
        end
    end

    assign o_rise      = rise_q;
    assign o_data_sync = data_sync_q;

endmodule

// File: rtl/i2s_rx_packer.sv
// i2s_rx_packer -- I2S receiver that packs serial samples into words for
// the sdramfifo.
//
// The codec clocks (bclk, lrclk) and data are asynchronous and are
// synchronised to i_clk, which must run at least 8x bclk.  Each channel
// word starts one bclk after the lrclk change (I2S delay), MSB first.
// Bits beyond DATA_WIDTH in a slot are ignored.  A word cut short by an
// early lrclk change is discarded and flagged on o_frame_err.
//
// Build option: define VOICE_DROP_CNT_EN to implement the dropped-word
// counter; otherwise o_drop_cnt is tied to zero.  Words completed while
// i_full is high are never written in either build.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_bclk       codec bit clock (asynchronous)
//   i_lrclk      codec word select (asynchronous), low = left
//   i_sdata      codec serial data (asynchronous)
//   i_full       downstream FIFO full
//   o_wr         one-cycle FIFO write strobe
//   o_data       sample word, valid with o_wr, held until the next write
//   o_frame_err  one-cycle pulse when a word is truncated
//   o_drop_cnt   saturating count of words dropped due to i_full
module i2s_rx_packer
    import voice_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int CHANNEL_SEL = CH_BOTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_bclk,
    input  logic                  i_lrclk,
    input  logic                  i_sdata,
    input  logic                  i_full,
    output logic                  o_wr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_frame_err,
    output logic [15:0]           o_drop_cnt
);

    localparam int   CNT_W     = $clog2(DATA_WIDTH + 1);
    localparam logic SEL_BOTH  = (CHANNEL_SEL == CH_BOTH);
    localparam logic SEL_RIGHT = (CHANNEL_SEL == CH_RIGHT);

    logic                  brise;
    logic [1:0]            din_sync;
    logic                  lr_s;
    logic                  sd_s;

    state_e                state_q;
    logic                  lr_prev_q;
    logic                  chan_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  wr_q;
    logic                  ferr_q;

    logic                  lr_change;
    logic                  last_bit;
    logic                  chan_en;
    logic [DATA_WIDTH-1:0] word_d;

    sync_edge #(
        .WIDTH(2)
    ) u_sync (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_edge     (i_bclk),
        .i_data     ({i_lrclk, i_sdata}),
        .o_rise     (brise),
        .o_data_sync(din_sync)
    );

    assign lr_s = din_sync[1];
    assign sd_s = din_sync[0];

    assign lr_change = (lr_s != lr_prev_q);
    // bit_cnt counts bits already in the shifter, so this brise carries
    // the LSB when DATA_WIDTH-1 bits are held.
    assign last_bit  = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));
    assign chan_en   = SEL_BOTH | (chan_q == SEL_RIGHT);
    assign word_d    = {shift_q[DATA_WIDTH-2:0], sd_s};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            lr_prev_q <= 1'b0;
            chan_q    <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            wr_q      <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            wr_q   <= 1'b0;
            ferr_q <= 1'b0;
            if (brise) begin
                lr_prev_q <= lr_s;
                case (state_q)
                    ST_IDLE, ST_WAIT: begin
                        if (lr_change) begin
                            state_q   <= ST_DELAY;
                            chan_q    <= lr_s;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_DELAY: begin
                        // First bclk after the lrclk change carries the MSB.
                        shift_q   <= {{(DATA_WIDTH-1){1'b0}}, sd_s};
                        bit_cnt_q <= CNT_W'(1);
                        state_q   <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (lr_change) begin
                            // Truncated word: drop it and resync on the new channel.
                            ferr_q    <= 1'b1;
                            state_q   <= ST_DELAY;
                            chan_q    <= lr_s;
                            bit_cnt_q <= '0;
                        end else begin
                            shift_q   <= word_d;
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            if (last_bit) begin
                                state_q <= ST_WAIT;
                                if (chan_en && !i_full) begin
                                    data_q <= word_d;
                                    wr_q   <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef VOICE_DROP_CNT_EN
    logic [15:0] drop_cnt_q;
    logic        drop_evt;

    // A selected word finishing while the FIFO is full is lost.
    assign drop_evt = brise && (state_q == ST_SHIFT) && !lr_change &&
                      last_bit && chan_en && i_full;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drop_cnt_q <= '0;
        end else if (drop_evt && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign o_drop_cnt = drop_cnt_q;
`else
    assign o_drop_cnt = 16'd0;
`endif

    assign o_wr        = wr_q;
    assign o_data      = data_q;
    assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_i2s_rx_packer.sv
// Directed bench for i2s_rx_packer: a stereo instance (CHANNEL_SEL=2) and
// a left-only instance (CHANNEL_SEL=0) share one I2S stream.
module tb_i2s_rx_packer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_bclk;
    logic        i_lrclk;
    logic        i_sdata;
    logic        i_full;

    logic        o_wr,  o_wr0;
    logic [15:0] o_data, o_data0;
    logic        o_frame_err, o_frame_err0;
    logic [15:0] o_drop_cnt, o_drop_cnt0;

`ifdef VOICE_DROP_CNT_EN
    localparam logic [15:0] EXP_DROP = 16'd1;
`else
    localparam logic [15:0] EXP_DROP = 16'd0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] wq[$];
    logic [15:0] wq0[$];
    int ferr_cycles = 0;

    always #5 i_clk = ~i_clk;

    i2s_rx_packer #(.DATA_WIDTH(16), .CHANNEL_SEL(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_bclk(i_bclk), .i_lrclk(i_lrclk),
        .i_sdata(i_sdata), .i_full(i_full), .o_wr(o_wr), .o_data(o_data),
        .o_frame_err(o_frame_err), .o_drop_cnt(o_drop_cnt)
    );

    i2s_rx_packer #(.DATA_WIDTH(16), .CHANNEL_SEL(0)) dut0 (
        .i_clk(i_clk), .i_rst(i_rst), .i_bclk(i_bclk), .i_lrclk(i_lrclk),
        .i_sdata(i_sdata), .i_full(i_full), .o_wr(o_wr0), .o_data(o_data0),
        .o_frame_err(o_frame_err0), .o_drop_cnt(o_drop_cnt0)
    );

    // Every cycle with o_wr high records one word, so a stretched strobe
    // shows up as an extra entry.
    always @(negedge i_clk) begin
        if (o_wr)  wq.push_back(o_data);
        if (o_wr0) wq0.push_back(o_data0);
        if (o_frame_err) ferr_cycles <= ferr_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bclk period (160 ns, 16 i_clk cycles); data changes on the falling edge.
    task automatic send_bit(input logic lr, input logic sd);
        i_lrclk = lr;
        i_sdata = sd;
        #80 i_bclk = 1'b1;
        #80 i_bclk = 1'b0;
    endtask

    // Slot: change bit, then nbits data bits MSB first, then pad bits.
    task automatic send_slot(input logic lr, input logic [15:0] w, input int nbits,
                             input int pad, input logic padval);
        send_bit(lr, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(lr, w[15-i]);
        for (int i = 0; i < pad; i++) send_bit(lr, padval);
    endtask

    initial begin
        int b, b0, fb;

        i_rst = 1'b1; i_bclk = 1'b0; i_lrclk = 1'b0; i_sdata = 1'b0; i_full = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        check("rst_wr",    o_wr,        1'b0);
        check("rst_data",  o_data,      16'h0000);
        check("rst_ferr",  o_frame_err, 1'b0);
        check("rst_drop",  o_drop_cnt,  16'h0000);
        i_rst = 1'b0;

        // Short right slot: truncated by the first left slot below.
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);

        // Stereo frame; left-only instance sees just the left word.
        b = wq.size(); b0 = wq0.size(); fb = ferr_cycles;
        send_slot(1'b0, 16'hA5C3, 16, 1, 1'b0);
        send_slot(1'b1, 16'h1234, 16, 1, 1'b0);
        #100;
        check("pre_ferr",   ferr_cycles - fb, 1);
        check("t1_nwr",     wq.size() - b, 2);
        check("t1_left",    wq[b], 16'hA5C3);
        check("t1_right",   wq[b+1], 16'h1234);
        check("t1_sel0_nwr", wq0.size() - b0, 1);
        check("t1_sel0_left", wq0[b0], 16'hA5C3);
        check("t1_hold",    o_data, 16'h1234);

        // FIFO full for the left word only.
        b = wq.size();
        i_full = 1'b1;
        send_slot(1'b0, 16'h5A5A, 16, 1, 1'b0);
        i_full = 1'b0;
        #100;
        check("t2_drop_nwr", wq.size() - b, 0);
        check("t2_hold",     o_data, 16'h1234);
        send_slot(1'b1, 16'h1234, 16, 1, 1'b0);
        #100;
        check("t2_nwr",   wq.size() - b, 1);
        check("t2_right", wq[b], 16'h1234);
        check("t2_drop",  o_drop_cnt, EXP_DROP);

        // Left word cut after 10 bits, then a clean right word.
        b = wq.size(); fb = ferr_cycles;
        send_slot(1'b0, 16'hFFFF, 10, 0, 1'b0);
        send_slot(1'b1, 16'h00FF, 16, 1, 1'b0);
        #100;
        check("t3_ferr",  ferr_cycles - fb, 1);
        check("t3_nwr",   wq.size() - b, 1);
        check("t3_right", wq[b], 16'h00FF);

        // 32-bit slots with trailing ones.
        b = wq.size(); fb = ferr_cycles;
        send_slot(1'b0, 16'h8001, 16, 15, 1'b1);
        send_slot(1'b1, 16'h4002, 16, 15, 1'b1);
        #100;
        check("t4_nwr",   wq.size() - b, 2);
        check("t4_left",  wq[b], 16'h8001);
        check("t4_right", wq[b+1], 16'h4002);
        check("t4_ferr",  ferr_cycles - fb, 0);

        // Reset in the middle of a left word.
        b = wq.size(); fb = ferr_cycles;
        send_slot(1'b0, 16'hC3C3, 8, 0, 1'b0);
        @(posedge i_clk); #1 i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("t5_rst_wr",   o_wr,       1'b0);
        check("t5_rst_data", o_data,     16'h0000);
        check("t5_rst_drop", o_drop_cnt, 16'h0000);
        i_rst = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b1);
        send_slot(1'b1, 16'h1234, 16, 1, 1'b0);
        #200;
        check("t5_nwr",   wq.size() - b, 1);
        check("t5_first", wq[b], 16'h1234);
        check("t5_ferr",  ferr_cycles - fb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
